// File: rtl/stream_access_control_if.sv
// stream_access_control_if: AXI-Stream, upsampler and CRF signals of the access-control path
interface stream_access_control_if #(
  parameter int DW = 32,
  parameter int CW = 32,
  parameter int AW = 32
);
  logic [CW-1:0] crf_ac_UPSTR;
  logic          crf_ac_wbusy;
  logic          ac_crf_wrt;
  logic [AW-1:0] ac_crf_waddr;
  logic [CW-1:0] ac_crf_wdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          upsp_ac_rd;
  logic          ac_upsp_rvalid;
  logic [DW-1:0] ac_upsp_rdata;
  logic          upsp_ac_wrt;
  logic [DW-1:0] upsp_ac_wdata;
  logic          ac_upsp_wready;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          busy;
  logic          err_eol;
  modport slave (
    input  crf_ac_UPSTR, crf_ac_wbusy, s_axis_tvalid, s_axis_tdata, s_axis_tlast,
           upsp_ac_rd, upsp_ac_wrt, upsp_ac_wdata, m_axis_tready,
    output ac_crf_wrt, ac_crf_waddr, ac_crf_wdata, s_axis_tready, ac_upsp_rvalid,
           ac_upsp_rdata, ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
           m_axis_tuser, busy, err_eol
  );
  modport master (
    output crf_ac_UPSTR, crf_ac_wbusy, s_axis_tvalid, s_axis_tdata, s_axis_tlast,
           upsp_ac_rd, upsp_ac_wrt, upsp_ac_wdata, m_axis_tready,
    input  ac_crf_wrt, ac_crf_waddr, ac_crf_wdata, s_axis_tready, ac_upsp_rvalid,
           ac_upsp_rdata, ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
           m_axis_tuser, busy, err_eol
  );
endinterface

// File: rtl/stream_access_control.sv
// stream_access_control: frame-level access control between AXI-Stream, upsampler and CRF
module stream_access_control #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int UPSP_DATA_WIDTH = 32,
  parameter int CRF_DATA_WIDTH  = 32,
  parameter int CRF_ADDR_WIDTH  = 32,
  parameter int SRC_IMG_WIDTH   = 1920,
  parameter int SRC_IMG_HEIGHT  = 1080,
  parameter int DST_IMG_WIDTH   = 4096,
  parameter int DST_IMG_HEIGHT  = 2160,
  parameter int OFIFO_DEPTH     = 16,
  parameter logic [CRF_ADDR_WIDTH-1:0] UPENDR_ADDR = 32'h4
) (
  input logic clk,
  input logic rst_n,
  stream_access_control_if.slave bus
);
  localparam int ST  = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
  localparam int DT  = DST_IMG_WIDTH * DST_IMG_HEIGHT;
  localparam int SCW = $clog2(ST + 1);
  localparam int DCW = $clog2(DT + 1);
  localparam int FAW = $clog2(OFIFO_DEPTH);
  localparam logic [SCW-1:0] S_COL_MAX = SCW'(SRC_IMG_WIDTH - 1);
  localparam logic [SCW-1:0] S_ROWS    = SCW'(SRC_IMG_HEIGHT);
  localparam logic [DCW-1:0] D_COL_MAX = DCW'(DST_IMG_WIDTH - 1);
  localparam logic [DCW-1:0] D_ROW_MAX = DCW'(DST_IMG_HEIGHT - 1);
  localparam logic [DCW-1:0] D_TOT     = DCW'(DT);

  if (AXIS_DATA_WIDTH != UPSP_DATA_WIDTH) begin : g_width_chk
    $error("stream_access_control: AXIS_DATA_WIDTH must equal UPSP_DATA_WIDTH");
  end
  if (OFIFO_DEPTH < 2 || (OFIFO_DEPTH & (OFIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("stream_access_control: OFIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic                       upstr_q;
  logic                       wrt_q;
  logic [CRF_ADDR_WIDTH-1:0]  waddr_q;
  logic [CRF_DATA_WIDTH-1:0]  wdata_q;
  logic                       in_full;
  logic [UPSP_DATA_WIDTH-1:0] in_data;
  logic [SCW-1:0]             src_col, src_row;
  logic                       err_q;
  logic [FAW:0]               wp, rp;
  logic [UPSP_DATA_WIDTH-1:0] mem [OFIFO_DEPTH];
  logic [DCW-1:0]             wr_cnt, out_col, out_row;
  logic run, start, consume, acc, push, pop, full, empty, last_out, src_eol;
  logic unused_upstr;

  assign unused_upstr = ^bus.crf_ac_UPSTR[CRF_DATA_WIDTH-1:1];

  assign run      = state == RUN;
  assign start    = state == IDLE && bus.crf_ac_UPSTR[0] && !upstr_q;
  assign consume  = in_full && bus.upsp_ac_rd;
  assign src_eol  = src_col == S_COL_MAX;
  assign acc      = bus.s_axis_tvalid && bus.s_axis_tready;
  assign empty    = wp == rp;
  assign full     = (wp[FAW] != rp[FAW]) && (wp[FAW-1:0] == rp[FAW-1:0]);
  assign push     = bus.upsp_ac_wrt && bus.ac_upsp_wready;
  assign pop      = !empty && bus.m_axis_tready;
  assign last_out = pop && out_col == D_COL_MAX && out_row == D_ROW_MAX;

  assign bus.s_axis_tready  = run && src_row != S_ROWS && (!in_full || consume);
  assign bus.ac_upsp_rvalid = in_full;
  assign bus.ac_upsp_rdata  = in_data;
  assign bus.ac_upsp_wready = !full && run && wr_cnt < D_TOT;
  assign bus.m_axis_tvalid  = !empty;
  assign bus.m_axis_tdata   = empty ? '0 : mem[rp[FAW-1:0]];
  assign bus.m_axis_tlast   = !empty && out_col == D_COL_MAX;
  assign bus.m_axis_tuser   = !empty && out_col == '0 && out_row == '0;
  assign bus.ac_crf_wrt     = wrt_q;
  assign bus.ac_crf_waddr   = waddr_q;
  assign bus.ac_crf_wdata   = wdata_q;
  assign bus.busy           = state != IDLE;
  assign bus.err_eol        = err_q;

  // Next state: start on a fresh UPSTR edge, finish on the last output handshake, leave DONE once the CRF takes the write
  always_comb begin
    state_nxt = state;
    if (start) state_nxt = RUN;
    else if (run && last_out) state_nxt = DONE;
    else if (state == DONE && !bus.crf_ac_wbusy) state_nxt = IDLE;
  end

  // State register, UPSTR edge history and the registered CRF write that is live exactly while in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      upstr_q <= 1'b0;
      wrt_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      upstr_q <= bus.crf_ac_UPSTR[0];
      wrt_q   <= state_nxt == DONE;
      waddr_q <= state_nxt == DONE ? UPENDR_ADDR : '0;
      wdata_q <= state_nxt == DONE ? CRF_DATA_WIDTH'(1) : '0;
    end
  end

  // One-entry skid towards upsp; a beat accepted while the old one leaves is registered, never bypassed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_full <= 1'b0;
      in_data <= '0;
    end else if (start) begin
      in_full <= 1'b0;
      in_data <= '0;
    end else begin
      in_full <= acc || (in_full && !consume);
      if (acc) in_data <= bus.s_axis_tdata;
    end
  end

  // Source position tracking; a misplaced tlast latches err_eol until reset but the beat still flows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_col <= '0;
      src_row <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_q || (acc && bus.s_axis_tlast != src_eol);
      if (start) begin
        src_col <= '0;
        src_row <= '0;
      end else if (acc) begin
        src_col <= src_eol ? '0 : src_col + SCW'(1);
        src_row <= src_eol ? src_row + SCW'(1) : src_row;
      end
    end
  end

  // Output FIFO pointers, push budget and destination raster position of the head beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      wr_cnt  <= '0;
      out_col <= '0;
      out_row <= '0;
    end else if (start) begin
      wp      <= '0;
      rp      <= '0;
      wr_cnt  <= '0;
      out_col <= '0;
      out_row <= '0;
    end else begin
      if (push) begin
        wp     <= wp + (FAW+1)'(1);
        wr_cnt <= wr_cnt + DCW'(1);
      end
      if (pop) begin
        rp      <= rp + (FAW+1)'(1);
        out_col <= out_col == D_COL_MAX ? '0 : out_col + DCW'(1);
        out_row <= out_col != D_COL_MAX ? out_row : out_row == D_ROW_MAX ? '0 : out_row + DCW'(1);
      end
    end
  end

  // FIFO storage; contents are only observable through the gated head
  always_ff @(posedge clk) begin
    if (push) mem[wp[FAW-1:0]] <= bus.upsp_ac_wdata;
  end
endmodule

// File: tb/tb_stream_access_control.sv
// tb_stream_access_control: scoreboard bench for a 4x2 -> 8x4 frame with a x4 echoing upsampler model
module tb_stream_access_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_access_control_if #(.DW(32), .CW(32), .AW(32)) bus ();

  stream_access_control #(
    .SRC_IMG_WIDTH(4), .SRC_IMG_HEIGHT(2),
    .DST_IMG_WIDTH(8), .DST_IMG_HEIGHT(4),
    .OFIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;
  int out_count = 0;
  logic [33:0] exp_q[$];
  logic flush = 1'b0;
  logic force_wr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_tready"}, bus.s_axis_tready, 0);
    check({tag, "_rvalid"}, bus.ac_upsp_rvalid, 0);
    check({tag, "_rdata"}, bus.ac_upsp_rdata, 0);
    check({tag, "_wready"}, bus.ac_upsp_wready, 0);
    check({tag, "_m_tvalid"}, bus.m_axis_tvalid, 0);
    check({tag, "_m_tdata"}, bus.m_axis_tdata, 0);
    check({tag, "_m_tlast"}, bus.m_axis_tlast, 0);
    check({tag, "_m_tuser"}, bus.m_axis_tuser, 0);
    check({tag, "_crf_wrt"}, bus.ac_crf_wrt, 0);
    check({tag, "_crf_waddr"}, bus.ac_crf_waddr, 0);
    check({tag, "_crf_wdata"}, bus.ac_crf_wdata, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_err_eol"}, bus.err_eol, 0);
  endtask

  // Upsampler model: takes each presented beat and returns it four times as beat+k
  initial begin : upsp_model
    logic [31:0] d;
    bit ok;
    int t;
    bus.upsp_ac_rd = 1'b0;
    bus.upsp_ac_wrt = 1'b0;
    bus.upsp_ac_wdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.upsp_ac_wrt = force_wr;
      if (rst_n && !flush && bus.ac_upsp_rvalid) begin
        d = bus.ac_upsp_rdata;
        bus.upsp_ac_rd = 1'b1;
        @(posedge clk); #1;
        bus.upsp_ac_rd = 1'b0;
        for (int k = 0; k < 4 && !flush; k++) begin
          bus.upsp_ac_wrt = 1'b1;
          bus.upsp_ac_wdata = d + 32'(k);
          ok = 0;
          t = 0;
          while (!ok && !flush && t < 500) begin
            @(negedge clk);
            ok = bus.ac_upsp_wready;
            @(posedge clk); #1;
            t++;
          end
        end
        bus.upsp_ac_wrt = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every m_axis handshake and checks stalled beats stay put
  initial begin : monitor
    logic [33:0] e;
    logic [31:0] held;
    bit stalled;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 0;
      else begin
        if (stalled) begin
          check("m_tvalid_held", bus.m_axis_tvalid, 1);
          check("m_tdata_held", bus.m_axis_tdata, held);
        end
        stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
        held = bus.m_axis_tdata;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          out_count++;
          if (exp_q.size() == 0) fail("m_axis_unexpected_beat");
          else begin
            e = exp_q.pop_front();
            check("m_axis_beat", {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata}, e);
          end
        end
      end
    end
  end

  task automatic send_src(input int err_beat);
    bit ok;
    int t;
    for (int i = 0; i < 8; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata = 32'(32'h100 * (i + 1));
      bus.s_axis_tlast = (i % 4 == 3) || i == err_beat;
      ok = 0;
      t = 0;
      while (!ok && !flush && t < 300) begin
        @(negedge clk);
        ok = bus.s_axis_tready;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) begin
        bus.s_axis_tvalid = 1'b0;
        if (!flush) fail("s_axis_accept");
        return;
      end
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({exp_idx == 0, exp_idx % 8 == 7, 32'(32'h100 * (i + 1) + k)});
        exp_idx++;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
  endtask

  task automatic do_stall();
    int t = 0;
    while (out_count < 10 && t < 500) begin @(posedge clk); #1; t++; end
    if (out_count < 10) fail("stall_trigger");
    bus.m_axis_tready = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check("stall_wready", bus.ac_upsp_wready, 0);
    check("stall_m_tvalid", bus.m_axis_tvalid, 1);
    bus.m_axis_tready = 1'b1;
  endtask

  task automatic start_frame(input bit hold);
    exp_q.delete();
    exp_idx = 0;
    out_count = 0;
    bus.crf_ac_UPSTR = 32'd1;
    @(posedge clk); #1;
    if (!hold) bus.crf_ac_UPSTR = 32'd0;
    check("busy_start", bus.busy, 1);
  endtask

  task automatic wait_done(input int nb);
    int t = 0;
    int n = 0;
    bus.crf_ac_wbusy = nb > 0;
    do begin @(negedge clk); t++; end while (!bus.ac_crf_wrt && t < 500);
    check("crf_wrt_seen", bus.ac_crf_wrt, 1);
    check("crf_waddr", bus.ac_crf_waddr, 4);
    check("crf_wdata", bus.ac_crf_wdata, 1);
    while (bus.ac_crf_wrt && n < 50) begin
      n++;
      @(posedge clk); #1;
      if (n == nb) bus.crf_ac_wbusy = 1'b0;
      @(negedge clk);
    end
    check("crf_wrt_cycles", n, nb + 1);
    check("busy_after_write", bus.busy, 0);
  endtask

  task automatic run_frame(input int err_beat, input bit stall, input int nb, input bit hold);
    start_frame(hold);
    fork
      send_src(err_beat);
      if (stall) do_stall();
    join
    wait_done(nb);
    check("out_count", out_count, 32);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : main
    int t;
    bus.crf_ac_UPSTR = '0;
    bus.crf_ac_wbusy = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tlast = 1'b0;
    bus.m_axis_tready = 1'b1;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("idle_busy", bus.busy, 0);

    run_frame(-1, 0, 0, 0);
    check("f1_err_eol", bus.err_eol, 0);

    run_frame(-1, 1, 5, 0);
    check("f2_err_eol", bus.err_eol, 0);

    run_frame(2, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("f3_err_eol_sticky", bus.err_eol, 1);

    start_frame(0);
    fork
      send_src(-1);
      begin
        t = 0;
        while (out_count < 10 && t < 500) begin @(posedge clk); #1; t++; end
        if (out_count < 10) fail("reset_trigger");
        rst_n = 1'b0;
        flush = 1'b1;
        #1;
        check_outputs_zero("midrst");
      end
    join
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_crf_wrt", bus.ac_crf_wrt, 0);
    end
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_idle", bus.busy, 0);

    run_frame(-1, 0, 0, 0);
    check("f5_err_eol", bus.err_eol, 0);

    run_frame(-1, 0, 2, 1);
    force_wr = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("hold_no_restart", bus.busy, 0);
    check("hold_wready_blocked", bus.ac_upsp_wready, 0);
    check("hold_m_tvalid", bus.m_axis_tvalid, 0);
    check("hold_out_count", out_count, 32);
    force_wr = 1'b0;
    bus.crf_ac_UPSTR = '0;
    repeat (2) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
